// File: rtl/pixel_write_buffer.sv
// Pixel write stage: clips draw-unit pixels, forms framebuffer addresses, queues writes and runs the frame-clear sweep.
// Optional build macro PIXWR_STATS_EN enables saturating write/clip statistics counters.
module pixel_write_buffer #(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 8
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [X_W-1:0]          pix_x,
  input  logic [Y_W-1:0]          pix_y,
  input  logic [15:0]             pix_color,
  input  logic                    clr_start,
  input  logic [15:0]             clr_color,
  output logic                    busy,
  output logic                    clip_drop,
  output logic                    fb_we,
  output logic [ADDR_W-1:0]       fb_addr,
  output logic [15:0]             fb_data,
  input  logic                    fb_ready,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [15:0]             wr_cnt,
  output logic [15:0]             clip_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  typedef enum logic [1:0] {PASS, DRAIN, CLEAR} state_t;
  state_t state_q, state_d;

  logic                    accept_p0, in_range_p0, push_p0;
  logic [ADDR_W-1:0]       addr_p0;
  logic                    vld_p1, clip_p1;
  logic [ADDR_W-1:0]       addr_p1;
  logic [15:0]             data_p1;
  logic [ADDR_W+15:0]      mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr, head_nxt;
  logic [CNT_W-1:0]        held;
  logic                    pop, clr_go;
  logic [15:0]             clr_col_q, clr_data;

  // Stage p0: handshake, clip test and linear address at accept time
  assign pix_ready   = (state_q == PASS) && (fifo_count < CNT_W'(DEPTH));
  assign accept_p0   = pix_valid && pix_ready;
  assign in_range_p0 = (int'(pix_x) < H_RES) && (int'(pix_y) < V_RES);
  assign push_p0     = accept_p0 && in_range_p0;
  assign addr_p0     = ADDR_W'(pix_y) * ADDR_W'(H_RES) + ADDR_W'(pix_x);

  // The presented head stays in the FIFO until the framebuffer takes it
  assign pop      = vld_p1 && fb_ready && (state_q != CLEAR);
  assign head_nxt = rd_ptr + PTR_W'(pop);
  assign held     = fifo_count - CNT_W'(pop);
  assign clr_go   = (state_d == CLEAR) && (state_q != CLEAR);
  assign clr_data = (state_q == PASS) ? clr_color : clr_col_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PASS:    if (clr_start) state_d = ((fifo_count != '0) || push_p0) ? DRAIN : CLEAR;
      DRAIN:   if (fifo_count == '0) state_d = CLEAR;
      CLEAR:   if (fb_ready && (addr_p1 == LAST_ADDR)) state_d = PASS;
      default: state_d = PASS;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= PASS;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      clip_p1    <= 1'b0;
    end else begin
      state_q <= state_d;
      clip_p1 <= accept_p0 && !in_range_p0;
      rd_ptr  <= head_nxt;
      if (push_p0) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({push_p0, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push_p0) mem[wr_ptr] <= {addr_p0, pix_color};
    if ((state_q == PASS) && clr_start) clr_col_q <= clr_color;
  end

  // Stage p1: registered write port, fed by the FIFO head or the clear sweep
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else if (clr_go) begin
      vld_p1  <= 1'b1;
      addr_p1 <= '0;
      data_p1 <= clr_data;
    end else if (state_q == CLEAR) begin
      if (fb_ready) begin
        if (addr_p1 == LAST_ADDR) vld_p1 <= 1'b0;
        else addr_p1 <= addr_p1 + ADDR_W'(1);
      end
    end else if (!vld_p1 || fb_ready) begin
      vld_p1 <= (held != '0);
      if (held != '0) {addr_p1, data_p1} <= mem[head_nxt];
    end
  end

  assign fb_we     = vld_p1;
  assign fb_addr   = addr_p1;
  assign fb_data   = data_p1;
  assign clip_drop = clip_p1;
  assign busy      = (state_q != PASS) || (fifo_count != '0);

`ifdef PIXWR_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] wr_cnt_q, clip_cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_cnt_q   <= '0;
      clip_cnt_q <= '0;
    end else begin
      if (pop) wr_cnt_q <= sat_inc(wr_cnt_q);
      if (accept_p0 && !in_range_p0) clip_cnt_q <= sat_inc(clip_cnt_q);
    end
  end

  assign wr_cnt   = wr_cnt_q;
  assign clip_cnt = clip_cnt_q;
`else
  assign wr_cnt   = '0;
  assign clip_cnt = '0;
`endif

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Self-checking bench for pixel_write_buffer: directed steps with random pixels, checked against a queue-based model.
module tb_pixel_write_buffer;
  localparam int H = 160;
  localparam int V = 120;

  logic        CLK, RST_N;
  logic        pix_valid, pix_ready;
  logic [7:0]  pix_x;
  logic [6:0]  pix_y;
  logic [15:0] pix_color;
  logic        clr_start;
  logic [15:0] clr_color;
  logic        busy, clip_drop, fb_we, fb_ready;
  logic [14:0] fb_addr;
  logic [15:0] fb_data;
  logic [3:0]  fifo_count;
  logic [15:0] wr_cnt, clip_cnt;

  pixel_write_buffer dut (
    .CLK(CLK), .RST_N(RST_N), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .clr_start(clr_start),
    .clr_color(clr_color), .busy(busy), .clip_drop(clip_drop), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready), .fifo_count(fifo_count),
    .wr_cnt(wr_cnt), .clip_cnt(clip_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending writes in order, plus the clear sweep in progress
  logic [31:0] q[$];
  bit          clearing = 1'b0;
  int          clr_idx = 0;
  logic [15:0] clr_col = '0;
  bit          clip_pend = 1'b0;
  bit          stall_prev = 1'b0;
  logic [14:0] st_addr = '0;
  logic [15:0] st_data = '0;
  int          exp_wr = 0, exp_clip = 0;
  int          n_pix = 0, n_clr = 0, n_clip = 0;
  int          last_addr = 0;
  logic [15:0] last_data = '0;
  int          rdy_mode = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    fb_ready = 1'b1;
    forever begin
      @(posedge CLK); #2;
      case (rdy_mode)
        0:       fb_ready = 1'b1;
        1:       fb_ready = ($urandom_range(3) != 0);
        default: fb_ready = 1'b0;
      endcase
    end
  end

  always @(negedge CLK) begin
    if (RST_N) begin
      check("pix_ready", 32'(pix_ready), 32'(!clearing && (q.size() < 8)));
      check("fifo_count", 32'(fifo_count), 32'(q.size()));
      check("busy", 32'(busy), 32'(clearing || (q.size() != 0)));
      check("clip_drop", 32'(clip_drop), 32'(clip_pend));
      if (stall_prev) begin
        check("stall_we", 32'(fb_we), 32'd1);
        check("stall_addr", 32'(fb_addr), 32'(st_addr));
        check("stall_data", 32'(fb_data), 32'(st_data));
      end
      stall_prev = fb_we && !fb_ready;
      st_addr = fb_addr;
      st_data = fb_data;
      if (fb_we && fb_ready) begin
        if (q.size() != 0) begin
          logic [31:0] e;
          e = q.pop_front();
          check("wr_addr", 32'(fb_addr), 32'(e[31:16]));
          check("wr_data", 32'(fb_data), 32'(e[15:0]));
          exp_wr++;
          n_pix++;
          last_addr = int'(fb_addr);
          last_data = fb_data;
        end else if (clearing) begin
          check("clr_addr", 32'(fb_addr), 32'(clr_idx));
          check("clr_data", 32'(fb_data), 32'(clr_col));
          clr_idx++;
          n_clr++;
          if (clr_idx == H * V) clearing = 1'b0;
        end else begin
          check("spurious_write", 32'(fb_we), 32'd0);
        end
      end
      clip_pend = 1'b0;
      if (pix_valid && pix_ready) begin
        if (int'(pix_x) < H && int'(pix_y) < V) begin
          int a;
          a = int'(pix_y) * H + int'(pix_x);
          q.push_back({a[15:0], pix_color});
        end else begin
          clip_pend = 1'b1;
          exp_clip++;
          n_clip++;
        end
      end
      if (clr_start && !clearing) begin
        clearing = 1'b1;
        clr_idx  = 0;
        clr_col  = clr_color;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send_pixel(input int x, input int y, input logic [15:0] c);
    int g = 0;
    pix_valid = 1'b1;
    pix_x = 8'(x);
    pix_y = 7'(y);
    pix_color = c;
    @(negedge CLK);
    while (!pix_ready && g < 2000) begin
      g++;
      @(negedge CLK);
    end
    check("accept", 32'(pix_ready), 32'd1);
    @(posedge CLK); #1;
    pix_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int g = 0;
    while ((q.size() != 0 || clearing) && g < budget) begin
      @(posedge CLK); #1;
      g++;
    end
    check(tag, 32'(q.size() == 0 && !clearing), 32'd1);
    repeat (2) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef PIXWR_STATS_EN
    check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'(exp_wr));
    check({tag, "_clip_cnt"}, 32'(clip_cnt), 32'(exp_clip));
`else
    check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd0);
    check({tag, "_clip_cnt"}, 32'(clip_cnt), 32'd0);
`endif
  endtask

  initial begin
    int p0, c0, k0, g;
    RST_N = 1'b0;
    pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_color = '0;
    clr_start = 1'b0; clr_color = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    check("rst_fb_data", 32'(fb_data), 32'd0);
    check("rst_clip_drop", 32'(clip_drop), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check_stats("rst");
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Single pixel
    p0 = n_pix;
    send_pixel(3, 2, 16'h07E0);
    wait_idle(200, "single_idle");
    check("single_count", 32'(n_pix - p0), 32'd1);
    check("single_addr", 32'(last_addr), 32'd323);
    check("single_data", 32'(last_data), 32'h07E0);
    check("single_fifo", 32'(fifo_count), 32'd0);

    // Clipping
    p0 = n_pix; k0 = n_clip;
    send_pixel(160, 0, 16'h1111);
    send_pixel(0, 120, 16'h2222);
    send_pixel(159, 119, 16'h3333);
    wait_idle(200, "clip_idle");
    check("clip_pulses", 32'(n_clip - k0), 32'd2);
    check("clip_writes", 32'(n_pix - p0), 32'd1);
    check("clip_addr", 32'(last_addr), 32'd19199);
    check("clip_data", 32'(last_data), 32'h3333);
`ifdef PIXWR_STATS_EN
    check("clip_cnt_2", 32'(clip_cnt), 32'd2);
`else
    check("clip_cnt_0", 32'(clip_cnt), 32'd0);
`endif

    // Backpressure: fill the FIFO, ninth offer must wait
    p0 = n_pix;
    rdy_mode = 2;
    for (int i = 0; i < 8; i++) send_pixel(i * 7, i, 16'($urandom));
    check("bp_count", 32'(fifo_count), 32'd8);
    check("bp_ready", 32'(pix_ready), 32'd0);
    pix_valid = 1'b1; pix_x = 8'd100; pix_y = 7'd50; pix_color = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      check("bp_hold_ready", 32'(pix_ready), 32'd0);
      check("bp_hold_count", 32'(fifo_count), 32'd8);
    end
    pix_valid = 1'b0;
    rdy_mode = 1;
    wait_idle(500, "bp_idle");
    check("bp_writes", 32'(n_pix - p0), 32'd8);

    // Push and pop on the same edge
    p0 = n_pix;
    rdy_mode = 2;
    for (int i = 0; i < 4; i++) send_pixel(20 + i, 30 + i, 16'($urandom));
    check("pp_count_before", 32'(fifo_count), 32'd4);
    check("pp_we", 32'(fb_we), 32'd1);
    rdy_mode = 0;
    send_pixel(40, 41, 16'h5A5A);
    check("pp_count_after", 32'(fifo_count), 32'd4);
    wait_idle(200, "pp_idle");
    check("pp_writes", 32'(n_pix - p0), 32'd5);

    // Random pixels with random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(2)) begin
        @(posedge CLK); #1;
      end
      send_pixel(int'($urandom_range(175)), int'($urandom_range(127)), 16'($urandom));
    end
    wait_idle(1000, "rand_idle");
    check_stats("rand");

    // Frame clear with three queued pixels and an ignored second request
    p0 = n_pix; c0 = n_clr;
    rdy_mode = 2;
    for (int i = 0; i < 3; i++) send_pixel(50 + i, 60, 16'hF0F0 + 16'(i));
    clr_start = 1'b1; clr_color = 16'h001F;
    @(posedge CLK); #1;
    clr_start = 1'b0; clr_color = 16'h7777;
    rdy_mode = 0;
    repeat (50) @(posedge CLK);
    #1;
    check("clr_busy_mid", 32'(busy), 32'd1);
    check("clr_ready_mid", 32'(pix_ready), 32'd0);
    clr_start = 1'b1; clr_color = 16'hF800;
    @(posedge CLK); #1;
    clr_start = 1'b0;
    wait_idle(25000, "clr_idle");
    check("clr_pix_writes", 32'(n_pix - p0), 32'd3);
    check("clr_sweep_writes", 32'(n_clr - c0), 32'd19200);
    check("clr_done_we", 32'(fb_we), 32'd0);
    check("clr_done_busy", 32'(busy), 32'd0);
    check_stats("clr");

    // Pixel with clear request, then reset mid-sweep
    rdy_mode = 1;
    pix_valid = 1'b1; pix_x = 8'd10; pix_y = 7'd10; pix_color = 16'hAAAA;
    clr_start = 1'b1; clr_color = 16'h1234;
    @(posedge CLK); #1;
    pix_valid = 1'b0; clr_start = 1'b0;
    g = 0;
    while (!(fb_we && fb_addr == 15'd5000) && g < 30000) begin
      @(posedge CLK); #1;
      g++;
    end
    check("rst_mid_reach", 32'(fb_addr), 32'd5000);
    #2;
    RST_N = 1'b0;
    q.delete();
    clearing = 1'b0; clip_pend = 1'b0; stall_prev = 1'b0;
    exp_wr = 0; exp_clip = 0;
    #1;
    check("rst_mid_we", 32'(fb_we), 32'd0);
    check("rst_mid_addr", 32'(fb_addr), 32'd0);
    check("rst_mid_data", 32'(fb_data), 32'd0);
    check("rst_mid_count", 32'(fifo_count), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check_stats("rst_mid");
    @(negedge CLK); #1;
    RST_N = 1'b1;
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check("post_rst_we", 32'(fb_we), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_ready", 32'(pix_ready), 32'd1);
    end
    p0 = n_pix;
    send_pixel(5, 5, 16'hC0DE);
    wait_idle(200, "post_rst_idle");
    check("post_rst_writes", 32'(n_pix - p0), 32'd1);
    check("post_rst_addr", 32'(last_addr), 32'd805);
    check("post_rst_data", 32'(last_data), 32'hC0DE);
    check_stats("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
